// File: rtl/motion_detect_pkg.sv
// Shared definitions for the motion-detect pipeline: frame geometry defaults,
// coordinate width and the frame sink state encoding.
package motion_detect_pkg;

    localparam int DEFAULT_WIDTH  = 768;
    localparam int DEFAULT_HEIGHT = 576;
    localparam int COORD_W        = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sink_state_t;

endpackage

// File: rtl/frame_sink_xy_counter.sv
// Raster-order column/row counter. It advances by one pixel per inc, wraps the
// column at WIDTH-1 and flags the last column and the last pixel of the frame.
module xy_counter
    import motion_detect_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_col,
    output logic               last_pix
);

    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;

    assign x        = x_reg;
    assign y        = y_reg;
    assign last_col = (x_reg == COORD_W'(WIDTH - 1));
    assign last_pix = last_col && (y_reg == COORD_W'(HEIGHT - 1));

    // Step through the frame in raster order; clear restarts at (0,0).
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (inc) begin
            if (last_col) begin
                x_reg <= '0;
                y_reg <= last_pix ? '0 : y_reg + COORD_W'(1);
            end else begin
                x_reg <= x_reg + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sink.sv
// Frame sink: pulls one frame of pixels from a first-word-fall-through FIFO
// per start, tags each pixel with its coordinates and frame markers, and
// presents it through a single-entry valid/ready output register.
module frame_sink
    import motion_detect_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_empty,
    input  logic [7:0]         in_dout,
    output logic               in_rd_en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [7:0]         out_pixel,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    output logic               frame_done,
    output logic [15:0]        frame_count
);

    sink_state_t        state_reg;
    logic               out_valid_reg;
    logic [7:0]         out_pixel_reg;
    logic [COORD_W-1:0] out_x_reg;
    logic [COORD_W-1:0] out_y_reg;
    logic               out_sof_reg;
    logic               out_eol_reg;
    logic               out_eof_reg;
    logic               frame_done_reg;
    logic [15:0]        frame_count_reg;

    logic               pop;
    logic               counter_clear;
    logic               eof_accept;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               last_col;
    logic               last_pix;

    // Pop only while capturing, when data exists and the output slot is free
    // or being emptied this cycle; reset blocks popping so the FIFO keeps its
    // residual words.
    assign pop           = !reset && (state_reg == RUN) && !in_empty
                           && (!out_valid_reg || out_ready);
    assign counter_clear = (state_reg == IDLE) && start;
    assign eof_accept    = out_valid_reg && out_ready && out_eof_reg;

    xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_xy_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (counter_clear),
        .inc      (pop),
        .x        (cur_x),
        .y        (cur_y),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    // Frame sequencing: arm on start, stop popping after the last pixel,
    // and finish once that last pixel has left the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (pop && last_pix) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (eof_accept) begin
                        state_reg       <= IDLE;
                        frame_done_reg  <= 1'b1;
                        frame_count_reg <= frame_count_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output holding register: load on pop (back-to-back with an accept),
    // otherwise drop valid once the held pixel is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_sof_reg   <= 1'b0;
            out_eol_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
        end else if (pop) begin
            out_valid_reg <= 1'b1;
            out_pixel_reg <= in_dout;
            out_x_reg     <= cur_x;
            out_y_reg     <= cur_y;
            out_sof_reg   <= (cur_x == '0) && (cur_y == '0);
            out_eol_reg   <= last_col;
            out_eof_reg   <= last_pix;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign in_rd_en    = pop;
    assign out_valid   = out_valid_reg;
    assign out_pixel   = out_pixel_reg;
    assign out_x       = out_x_reg;
    assign out_y       = out_y_reg;
    assign out_sof     = out_sof_reg;
    assign out_eol     = out_eol_reg;
    assign out_eof     = out_eof_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_sink.sv
// Self-checking bench for frame_sink with a 4x2 frame geometry.
module tb_frame_sink;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_empty;
    logic [7:0]  in_dout;
    logic        in_rd_en;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;
    logic [15:0] frame_count;

    always #5 clock = ~clock;

    frame_sink #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .in_rd_en    (in_rd_en),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_pixel   (out_pixel),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    // upstream FIFO contents and stall control
    logic [7:0]  fifo_q[$];
    bit          stall;
    int          n_chk;
    int          n_fail;

    // reference model: pixel index within the frame plus the held output slot
    int          m_phase;      // 0 idle, 1 capturing, 2 waiting for last pixel to leave
    int          m_idx;
    bit          m_valid;
    logic [7:0]  m_pix;
    int          m_x;
    int          m_y;
    bit          m_sof;
    bit          m_eol;
    bit          m_eof;
    bit          m_done;
    logic [15:0] m_count;
    int          done_pulses;

    // accepted-pixel log and expected stream
    logic [7:0]  acc_pix[$];
    int          acc_x[$];
    int          acc_y[$];
    bit          acc_sof[$];
    bit          acc_eol[$];
    logic [7:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        in_empty = stall || (fifo_q.size() == 0);
        in_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic cyc();
        bit         exp_rd;
        bit         accept;
        bit         held_eof;
        int         ph_old;
        logic [7:0] p;
        @(negedge clock);
        drive_fifo();
        #4;
        exp_rd = !reset && (m_phase == 1) && !in_empty && (!m_valid || out_ready);
        chk("in_rd_en", {31'b0, in_rd_en}, {31'b0, exp_rd});
        accept   = m_valid && out_ready && !reset;
        held_eof = m_valid && (m_x == W - 1) && (m_y == H - 1);
        if (accept) begin
            acc_pix.push_back(out_pixel);
            acc_x.push_back(int'(out_x));
            acc_y.push_back(int'(out_y));
            acc_sof.push_back(out_sof);
            acc_eol.push_back(out_eol);
            $display("accept pixel=%02h x=%0d y=%0d sof=%0b eol=%0b eof=%0b",
                     out_pixel, out_x, out_y, out_sof, out_eol, out_eof);
        end
        ph_old = m_phase;
        @(posedge clock);
        #1;
        if (reset) begin
            m_phase = 0; m_idx = 0; m_valid = 0; m_pix = 8'h00;
            m_x = 0; m_y = 0; m_sof = 0; m_eol = 0; m_eof = 0;
            m_done = 0; m_count = 16'h0000;
        end else begin
            m_done = 0;
            if (exp_rd) begin
                p       = fifo_q.pop_front();
                m_valid = 1;
                m_pix   = p;
                m_x     = m_idx % W;
                m_y     = m_idx / W;
                m_sof   = (m_idx == 0);
                m_eol   = (m_x == W - 1);
                m_eof   = (m_idx == NPIX - 1);
                m_idx++;
                if (m_idx == NPIX) m_phase = 2;
            end else if (accept) begin
                m_valid = 0;
            end
            if (ph_old == 2 && accept && held_eof) begin
                m_phase = 0;
                m_done  = 1;
                m_count = m_count + 16'd1;
                done_pulses++;
            end
            if (ph_old == 0 && start) begin
                m_phase = 1;
                m_idx   = 0;
            end
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("frame_done", {31'b0, frame_done}, {31'b0, m_done});
        chk("frame_count", {16'b0, frame_count}, {16'b0, m_count});
        if (m_valid || reset) begin
            chk("out_pixel", {24'b0, out_pixel}, {24'b0, m_pix});
            chk("out_x", {22'b0, out_x}, m_x);
            chk("out_y", {22'b0, out_y}, m_y);
            chk("out_sof", {31'b0, out_sof}, {31'b0, m_sof});
            chk("out_eol", {31'b0, out_eol}, {31'b0, m_eol});
            chk("out_eof", {31'b0, out_eof}, {31'b0, m_eof});
        end
    endtask

    task automatic load_frame(input int base, input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < NPIX; i++) begin
            v = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
            fifo_q.push_back(v);
            exp_q.push_back(v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // mode 0: always ready; 1: ready toggles; 2: random ready and stalls
    task automatic run_frames(input int nframes, input int mode, input int budget);
        int target;
        target = done_pulses + nframes;
        for (int i = 0; i < budget && done_pulses < target; i++) begin
            case (mode)
                1:       out_ready = !out_ready;
                2: begin
                    out_ready = 1'($urandom_range(0, 1));
                    stall     = ($urandom_range(0, 3) == 0);
                end
                default: out_ready = 1'b1;
            endcase
            cyc();
        end
        stall = 1'b0;
        chk("frame_within_budget", done_pulses, target);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, acc_pix.size(), exp_q.size());
        for (int i = 0; i < acc_pix.size() && i < exp_q.size(); i++) begin
            chk({tag, "_pix"}, {24'b0, acc_pix[i]}, {24'b0, exp_q[i]});
        end
        acc_pix.delete(); acc_x.delete(); acc_y.delete();
        acc_sof.delete(); acc_eol.delete(); exp_q.delete();
    endtask

    initial begin
        int dp0;
        n_chk = 0; n_fail = 0; done_pulses = 0;
        m_phase = 0; m_idx = 0; m_valid = 0; m_pix = 8'h00; m_x = 0; m_y = 0;
        m_sof = 0; m_eol = 0; m_eof = 0; m_done = 0; m_count = 16'h0000;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; stall = 1'b0;
        drive_fifo();

        // reset state
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // case 1: straight frame
        load_frame(8'h10, 1'b0);
        out_ready = 1'b1;
        pulse_start();
        run_frames(1, 0, 40);
        chk("c1_sof_first", {31'b0, acc_sof[0]}, 32'd1);
        chk("c1_eol_0x13", {31'b0, acc_eol[3]}, 32'd1);
        chk("c1_eol_0x17", {31'b0, acc_eol[7]}, 32'd1);
        check_stream("c1");
        chk("c1_count", {16'b0, frame_count}, 32'd1);
        cyc();

        // case 2: downstream back-pressure
        load_frame(8'h10, 1'b0);
        pulse_start();
        run_frames(1, 1, 60);
        check_stream("c2");
        out_ready = 1'b1;
        cyc();

        // case 3: upstream empty for 5 cycles after 3 pixels
        load_frame(8'h20, 1'b0);
        pulse_start();
        for (int i = 0; i < 20 && m_idx < 3; i++) cyc();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        stall = 1'b0;
        run_frames(1, 0, 40);
        chk("c3_x4", acc_x[3], 32'd3);
        chk("c3_y4", acc_y[3], 32'd0);
        chk("c3_eol4", {31'b0, acc_eol[3]}, 32'd1);
        check_stream("c3");

        // case 4: reset mid-frame
        load_frame(8'h30, 1'b0);
        pulse_start();
        for (int i = 0; i < 20 && acc_pix.size() < 5; i++) cyc();
        chk("c4_five_seen", acc_pix.size(), 32'd5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        fifo_q.delete();
        acc_pix.delete(); acc_x.delete(); acc_y.delete();
        acc_sof.delete(); acc_eol.delete(); exp_q.delete();
        load_frame(8'h40, 1'b0);
        pulse_start();
        run_frames(1, 0, 40);
        chk("c4_restart_sof", {31'b0, acc_sof[0]}, 32'd1);
        chk("c4_restart_x", acc_x[0], 32'd0);
        check_stream("c4");

        // case 5: start held across two frames
        dp0 = done_pulses;
        load_frame(8'h50, 1'b0);
        load_frame(8'h60, 1'b0);
        start = 1'b1;
        run_frames(2, 0, 80);
        start = 1'b0;
        cyc();
        cyc();
        chk("c5_done_pulses", done_pulses - dp0, 32'd2);
        check_stream("c5");

        // random data with random back-pressure and stalls
        for (int f = 0; f < 3; f++) begin
            load_frame(0, 1'b1);
            pulse_start();
            run_frames(1, 2, 200);
            check_stream("rnd");
        end
        out_ready = 1'b1;
        cyc();

        // case 6: frame counter wrap
        force dut.frame_count_reg = 16'hFFFE;
        m_count = 16'hFFFE;
        cyc();
        release dut.frame_count_reg;
        cyc();
        load_frame(8'h70, 1'b0);
        pulse_start();
        run_frames(1, 0, 40);
        chk("c6_ffff", {16'b0, frame_count}, 32'h0000FFFF);
        check_stream("c6a");
        load_frame(8'h78, 1'b0);
        pulse_start();
        run_frames(1, 0, 40);
        chk("c6_wrap", {16'b0, frame_count}, 32'h00000000);
        check_stream("c6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sink.md
FRAME_SINK -- requirements
Module: frame_sink

Interface
REQ-001 Parameter WIDTH, default 768, pixels per line; legal range 2 to 1024.
REQ-002 Parameter HEIGHT, default 576, lines per frame; legal range 2 to 1024.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; the ports are named clock and reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  arms capture of one frame; sampled only in IDLE.
REQ-007 in_empty  in  1  upstream FIFO empty flag.
REQ-008 in_dout  in  8  upstream FIFO data; first-word-fall-through, valid whenever in_empty=0.
REQ-009 in_rd_en  out  1  pops upstream FIFO.
REQ-010 out_ready  in  1  downstream accepts the held pixel.
REQ-011 out_valid  out  1  out_* holds a valid pixel.
REQ-012 out_pixel  out  8  pixel value.
REQ-013 out_x  out  10  column of the held pixel.
REQ-014 out_y  out  10  row of the held pixel.
REQ-015 out_sof  out  1  held pixel is (0,0).
REQ-016 out_eol  out  1  held pixel has x=WIDTH-1.
REQ-017 out_eof  out  1  held pixel is (WIDTH-1,HEIGHT-1).
REQ-018 frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-019 frame_count  out  16  completed frames; wraps from 0xFFFF to 0.

Function
REQ-020 The state machine SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-021 In IDLE with start=1, the next state SHALL be RUN and the x/y counters SHALL clear to 0.
REQ-022 in_rd_en SHALL equal (state==RUN) && !in_empty && (!out_valid || out_ready), combinationally.
REQ-023 On a pop, the output register SHALL load in_dout and the current x/y, and out_valid SHALL be 1 on the next cycle (latency 1 from the pop).
REQ-024 out_sof, out_eol and out_eof SHALL be registered together with the pixel.
REQ-025 On a pop, x SHALL increment; when x==WIDTH-1, x SHALL go to 0 and y SHALL increment.
REQ-026 A pop at (WIDTH-1,HEIGHT-1) SHALL move the state to DRAIN, and no further pops occur until the next start.
REQ-027 When out_valid && out_ready and no pop occurs in that cycle, out_valid SHALL clear on the next cycle.
REQ-028 A simultaneous accept and pop SHALL replace the held pixel with no bubble, sustaining 1 pixel per clock.
REQ-029 While out_valid=1 and out_ready=0, all out_* outputs SHALL hold stable.
REQ-030 In DRAIN, when the eof pixel is accepted: frame_done SHALL pulse on the next cycle, frame_count SHALL increment on the same edge, and the state SHALL return to IDLE.
REQ-031 start SHALL be ignored in RUN and DRAIN.
REQ-032 in_empty=1 in RUN SHALL stall popping without changing the counters.

Reset
REQ-033 reset SHALL have priority over all other inputs in every state, including mid-frame.
REQ-034 On reset: state=IDLE; x=0; y=0; out_valid=0; out_pixel, out_x and out_y =0; out_sof, out_eol and out_eof =0; frame_done=0; frame_count=0.
REQ-035 During and after reset, up to the next start, in_rd_en SHALL be 0.
REQ-036 Reset SHALL NOT drain the upstream FIFO; residual words remain in it.

Structure
REQ-037 The shared package motion_detect_pkg SHALL hold the WIDTH/HEIGHT defaults, the coordinate width constant (10), and the sink_state_t enum {IDLE, RUN, DRAIN}.
REQ-038 Sub-module xy_counter SHALL implement the x/y wrap counter, with inputs clear and inc and outputs x, y, last_col and last_pix.
REQ-039 All outputs SHALL be registered except in_rd_en.

Verification (WIDTH=4, HEIGHT=2 unless stated)
REQ-040 Case 1: start pulse, FIFO preloaded with 8 bytes 0x10..0x17, out_ready=1 -> 8 consecutive out_valid cycles with pixels 0x10..0x17; sof on 0x10; eol on 0x13 and 0x17; eof on 0x17; frame_done 1 cycle after 0x17; frame_count=1.
REQ-041 Case 2: same stimulus with out_ready toggling 1,0 -> each pixel held stable while out_ready=0, with no loss or duplication, and the same sequence as Case 1.
REQ-042 Case 3: in_empty=1 for 5 cycles after 3 pixels -> in_rd_en=0 and counters frozen; the 4th pixel carries out_x=3, out_y=0 and eol=1.
REQ-043 Case 4: reset asserted after 5 pixels -> next cycle: all outputs 0 and state IDLE; a following start restarts at (0,0) with sof=1.
REQ-044 Case 5: start held high across two frames -> exactly 16 pixels, two frame_done pulses, and frame_count=2; start asserted during RUN has no effect.
REQ-045 Case 6: frame_count forced near wrap (default parameters, 65536 frames or force) -> 0xFFFF is followed by 0x0000.
